branch_resolve_ctrl: RTL

//  Sequences branch resolution for the RV32I core. Holds a 2-bit-counter branch history table (BHT)

---
 rtl/branch_pkg.sv | 41 ++++
 rtl/bht_2bit.sv | 33 +++
 rtl/branch_resolve_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared types and helpers for branch prediction and resolution.
package branch_pkg;

  // 2-bit saturating direction counter; MSB is the predicted direction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } brc_state_t;

  localparam bht_state_t BHT_RESET_VAL = WNT;

  // Conditional branch funct3 encodings, shared with branch_con.
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Saturating counter step toward the resolved direction.
  function automatic bht_state_t bht_next(input bht_state_t cur, input logic taken);
    bht_state_t nxt;
    nxt = cur;
    unique case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = BHT_RESET_VAL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table: async read for fetch, sync saturating update from execute.
module bht_2bit
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output bht_state_t       o_rd_state,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);

  bht_state_t r_bht [DEPTH];

  // Table storage: reset every entry to weakly not-taken, else saturating update on write.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_bht[i] <= BHT_RESET_VAL;
      end
    end else if (i_wr_en) begin
      r_bht[i_wr_idx] <= bht_next(r_bht[i_wr_idx], i_wr_taken);
    end
  end

  // No write bypass: a same-index read in the update cycle sees the old value.
  assign o_rd_state = r_bht[i_rd_idx];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution: BHT prediction, mispredict redirect, IF/ID flush, perf counters.
module branch_resolve_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned BHT_DEPTH    = 64,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_if_valid,
  input  logic [31:0]      i_if_pc,
  output logic             o_if_pred_taken,
  input  logic             i_ex_valid,
  input  logic             i_ex_is_branch,
  input  logic             i_ex_is_jump,
  input  logic [31:0]      i_ex_pc,
  input  logic             i_ex_pred_taken,
  input  logic             i_ex_br_taken,
  input  logic [31:0]      i_ex_target,
  output logic             o_redirect_valid,
  output logic [31:0]      o_redirect_pc,
  output logic             o_flush_if,
  output logic             o_flush_id,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);
  localparam int unsigned FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  brc_state_t        r_state, w_state_next;
  logic [FC_W-1:0]   r_flush_cnt;
  logic              r_redirect_valid;
  logic [31:0]       r_redirect_pc;
  logic [CNT_W-1:0]  r_branch_cnt, r_mispred_cnt;

  bht_state_t        w_if_state;
  logic [IDX_W-1:0]  w_if_idx, w_ex_idx;
  logic              w_is_br, w_res, w_actual, w_mispred, w_bht_we;
  logic [31:0]       w_fallthru;

  assign w_if_idx   = i_if_pc[IDX_W+1:2];
  assign w_ex_idx   = i_ex_pc[IDX_W+1:2];
  // A jump flagged as a branch too is resolved as a jump.
  assign w_is_br    = i_ex_is_branch & ~i_ex_is_jump;
  assign w_res      = i_ex_valid & (i_ex_is_branch | i_ex_is_jump) & (r_state == IDLE);
  assign w_actual   = i_ex_is_jump | i_ex_br_taken;
  assign w_mispred  = w_res & (w_actual != i_ex_pred_taken);
  assign w_bht_we   = w_res & w_is_br;
  assign w_fallthru = i_ex_pc + 32'd4;

  bht_2bit #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rd_idx   (w_if_idx),
    .o_rd_state (w_if_state),
    .i_wr_en    (w_bht_we),
    .i_wr_idx   (w_ex_idx),
    .i_wr_taken (i_ex_br_taken)
  );

  assign o_if_pred_taken = i_if_valid & w_if_state[1];

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // FSM next state: a mispredict starts a flush window of FLUSH_CYCLES cycles.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_mispred) w_state_next = FLUSH;
      FLUSH:   if (r_flush_cnt == '0) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    o_busy     = 1'b0;
    o_flush_if = 1'b0;
    o_flush_id = 1'b0;
    if (r_state == FLUSH) begin
      o_busy     = 1'b1;
      o_flush_if = 1'b1;
      o_flush_id = 1'b1;
    end
  end

  // Remaining flush cycles after the current one; loaded on entry to FLUSH.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                 r_flush_cnt <= '0;
    else if (w_mispred)           r_flush_cnt <= FC_LOAD;
    else if (r_flush_cnt != '0)   r_flush_cnt <= r_flush_cnt - 1'b1;
  end

  // Redirect pulse and latched target, valid in the first FLUSH cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_redirect_valid <= w_mispred;
      if (w_mispred) r_redirect_pc <= w_actual ? i_ex_target : w_fallthru;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_bht_we && (r_branch_cnt != {CNT_W{1'b1}}))   r_branch_cnt  <= r_branch_cnt + 1'b1;
      if (w_mispred && (r_mispred_cnt != {CNT_W{1'b1}})) r_mispred_cnt <= r_mispred_cnt + 1'b1;
    end
  end

  assign o_redirect_valid = r_redirect_valid;
  assign o_redirect_pc    = r_redirect_pc;
  assign o_branch_cnt     = r_branch_cnt;
  assign o_mispred_cnt    = r_mispred_cnt;

endmodule
